// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and helpers for the HI/LO multiply/divide unit
package muldiv_pkg;
  typedef enum logic [3:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    MADD  = 4'd2,
    MADDU = 4'd3,
    MSUB  = 4'd4,
    MSUBU = 4'd5,
    DIV   = 4'd6,
    DIVU  = 4'd7,
    MTHI  = 4'd8,
    MTLO  = 4'd9
  } mdop_t;
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} md_state_t;
  function automatic logic is_div(mdop_t op);
    return op == DIV || op == DIVU;
  endfunction
endpackage

// File: rtl/ffd.sv
// ffd: register cell with synchronous reset and enable
module ffd #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/muldiv_seq_div_iter.sv
// div_iter: unsigned restoring divider retiring one quotient bit per step
module div_iter #(parameter int W = 32, parameter int STEPS = W) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         last
);
  localparam int CW = $clog2(STEPS);
  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic [W:0]    diff;
  // quotient doubles as the dividend shifter: dividend bits leave the top, quotient bits enter the bottom
  assign diff = {remainder, quotient[W-1]} - {1'b0, dvs};
  assign last = cnt == '0;
  always_ff @(posedge clk)
    if (rst) begin
      remainder <= '0;
      quotient  <= '0;
      dvs       <= '0;
      cnt       <= '0;
    end else if (load) begin
      remainder <= '0;
      quotient  <= dividend;
      dvs       <= divisor;
      cnt       <= CW'(STEPS - 1);
    end else if (step) begin
      remainder <= diff[W] ? {remainder[W-2:0], quotient[W-1]} : diff[W-1:0];
      quotient  <= {quotient[W-2:0], ~diff[W]};
      cnt       <= cnt - 1'b1;
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential HI/LO multiply, multiply-accumulate and iterative divide unit
module muldiv_seq import muldiv_pkg::*; #(
  parameter int W = 32,
  parameter int DIV_STEPS = W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  mdop_t        op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  md_state_t state;
  logic neg_q, neg_r, accept, sgn, mul_op, fix, last, hi_en, lo_en;
  logic [W-1:0] mag_a, mag_b, q, r, hi_d, lo_d;
  logic [2*W-1:0] ext_a, ext_b, prod, res;
  assign accept = start && state == S_IDLE;
  assign sgn    = !op[0];
  assign mul_op = op <= MSUBU;
  assign fix    = state == S_FIX;
  assign busy   = state != S_IDLE;
  // the low 2W bits of a 2W x 2W product are correct for both signednesses once extended
  assign ext_a  = {{W{sgn & a[W-1]}}, a};
  assign ext_b  = {{W{sgn & b[W-1]}}, b};
  assign prod   = ext_a * ext_b;
  assign res    = op inside {MADD, MADDU} ? {hi, lo} + prod :
                  op inside {MSUB, MSUBU} ? {hi, lo} - prod : prod;
  assign mag_a  = sgn && a[W-1] ? -a : a;
  assign mag_b  = sgn && b[W-1] ? -b : b;
  assign hi_en  = fix || accept && (mul_op || op == MTHI);
  assign lo_en  = fix || accept && (mul_op || op == MTLO);
  assign hi_d   = fix ? (neg_r ? -r : r) : op == MTHI ? a : res[2*W-1:W];
  assign lo_d   = fix ? (neg_q ? -q : q) : op == MTLO ? a : res[W-1:0];
  div_iter #(.W(W), .STEPS(DIV_STEPS)) u_div (
    .clk(clk), .rst(reset), .load(accept && is_div(op)), .step(state == S_DIV),
    .dividend(mag_a), .divisor(mag_b), .quotient(q), .remainder(r), .last(last)
  );
  ffd #(.W(W)) u_hi (.clk(clk), .rst(reset), .en(hi_en), .d(hi_d), .q(hi));
  ffd #(.W(W)) u_lo (.clk(clk), .rst(reset), .en(lo_en), .d(lo_d), .q(lo));
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      done  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= fix || accept && (mul_op || op == MTHI || op == MTLO);
      if (accept && is_div(op)) begin
        state <= S_DIV;
        neg_q <= sgn && (a[W-1] ^ b[W-1]);
        neg_r <= sgn && a[W-1];
      end else if (state == S_DIV && last) state <= S_FIX;
      else if (fix) state <= S_IDLE;
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table, corner-sequence and randomized checks of muldiv_seq against a behavioural model
module tb_muldiv_seq;
  import muldiv_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset, start, busy, done;
  mdop_t op;
  logic [W-1:0] a, b, hi, lo;
  logic [W-1:0] mhi, mlo;
  int passed = 0, total = 0;
  typedef struct {
    mdop_t op;
    logic [W-1:0] a, b, hi, lo;
    int bc;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  muldiv_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // issue one op and wait (bounded) for DONE; optionally drive junk starts while busy
  task automatic exec(mdop_t o, logic [W-1:0] x, logic [W-1:0] y, bit noise, output int bcyc, output bit seen);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    bcyc = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      start = 1'b0;
      if (done) begin seen = 1'b1; break; end
      if (busy) begin
        bcyc++;
        if (noise) begin
          start = 1'($urandom_range(1));
          op = mdop_t'($urandom_range(9));
          a = $urandom; b = $urandom;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  function automatic void model(mdop_t o, logic [W-1:0] x, logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy;
    logic [2*W-1:0] p, acc;
    logic signed [W-1:0] qs, rs;
    sx = $signed(x);
    sy = $signed(y);
    acc = {mhi, mlo};
    p = (o inside {MULT, MADD, MSUB}) ? sx * sy : {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      MULT, MULTU: {mhi, mlo} = p;
      MADD, MADDU: {mhi, mlo} = acc + p;
      MSUB, MSUBU: {mhi, mlo} = acc - p;
      MTHI: mhi = x;
      MTLO: mlo = x;
      DIVU:
        if (y == 0) begin mlo = '1; mhi = x; end
        else begin mlo = x / y; mhi = x % y; end
      DIV:
        if (y == 0) begin mlo = x[W-1] ? W'(1) : '1; mhi = x; end
        else if (x == {1'b1, {(W-1){1'b0}}} && y == '1) begin mlo = x; mhi = '0; end
        else begin
          qs = $signed(x) / $signed(y);
          rs = $signed(x) % $signed(y);
          mlo = qs; mhi = rs;
        end
      default: ;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  initial begin
    int bc, dcount;
    bit seen;
    mdop_t o;
    logic [W-1:0] x, y;
    tbl[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0};
    tbl[1]  = '{MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0};
    tbl[2]  = '{MTHI,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 0};
    tbl[3]  = '{MTLO,  32'd10,        32'h0000_0000, 32'h0000_0000, 32'd10,        0};
    tbl[4]  = '{MADD,  32'hFFFF_FFFD, 32'd4,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 0};
    tbl[5]  = '{MSUBU, 32'd1,         32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFC, 0};
    tbl[6]  = '{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, W+1};
    tbl[7]  = '{DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         W+1};
    tbl[8]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, W+1};
    tbl[9]  = '{DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, W+1};
    tbl[10] = '{DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'd1,         W+1};
    tbl[11] = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, W+1};
    reset = 1'b1; start = 1'b0; op = MULT; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    for (int i = 0; i < 12; i++) begin
      exec(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, bc, seen);
      check($sformatf("v%0d done", i), W'(seen), 1);
      check($sformatf("v%0d busy_cycles", i), bc, tbl[i].bc);
      check($sformatf("v%0d hi", i), hi, tbl[i].hi);
      check($sformatf("v%0d lo", i), lo, tbl[i].lo);
      @(negedge clk);
      check($sformatf("v%0d done_pulse", i), W'(done), '0);
    end
    mhi = tbl[11].hi; mlo = tbl[11].lo;
    // undefined op: no write, no DONE
    start = 1'b1; op = mdop_t'(4'hC); a = 32'h1234_5678; b = 32'h9;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    repeat (3) begin
      dcount += int'(done);
      @(negedge clk);
    end
    check("nop done", dcount, 0);
    check("nop hi", hi, mhi);
    check("nop lo", lo, mlo);
    // MULT issued mid-divide must be ignored
    start = 1'b1; op = DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid busy", W'(busy), 1);
    start = 1'b1; op = MULT; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check("ignored done", W'(seen), 1);
    check("ignored hi", hi, 32'd2);
    check("ignored lo", lo, 32'd14);
    @(negedge clk);
    check("ignored no replay", W'(done), '0);
    check("ignored hold lo", lo, 32'd14);
    // reset aborts an in-flight divide
    start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort busy before", W'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", W'(busy), '0);
    check("abort hi", hi, '0);
    check("abort lo", lo, '0);
    check("abort done", W'(done), '0);
    dcount = 0;
    repeat (40) begin
      dcount += int'(done);
      @(negedge clk);
    end
    check("abort no late done", dcount, 0);
    mhi = '0; mlo = '0;
    for (int n = 0; n < 300; n++) begin
      o = mdop_t'($urandom_range(9));
      x = $urandom; y = $urandom;
      if ($urandom_range(15) == 0) y = '0;
      if ($urandom_range(31) == 0) begin x = 32'h8000_0000; y = '1; end
      exec(o, x, y, 1'b1, bc, seen);
      model(o, x, y);
      check($sformatf("r%0d %s done", n, o.name()), W'(seen), 1);
      check($sformatf("r%0d %s busy_cycles", n, o.name()), bc, is_div(o) ? W + 1 : 0);
      check($sformatf("r%0d %s hi a=%h b=%h", n, o.name(), x, y), hi, mhi);
      check($sformatf("r%0d %s lo a=%h b=%h", n, o.name(), x, y), lo, mlo);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Parametrised successor to the single-cycle HI/LO multiplier. Provides signed/unsigned multiply, multiply-accumulate/subtract, iterative radix-2 divide and direct HI/LO writes behind one start/busy handshake. Sits beside the execute stage. The pipeline stalls on BUSY before reading HI/LO or issuing a new op.

Parameters:
W, 32, operand width; HI and LO are each W bits; the product is 2W bits.
DIV_STEPS, W, quotient bits retired per divide (one per cycle); must equal W, kept as a parameter for verification override only.

Ports:
CLK  in  1  clock; all state changes on the rising edge
RESET  in  1  synchronous, active-high reset
START  in  1  issue OP this cycle; ignored while BUSY=1
OP  in  4  operation code (mdop_t, see Decomposition)
A  in  W  operand A / dividend / MTHI-MTLO data
B  in  W  operand B / divisor
BUSY  out  1  divide in progress; HI/LO not valid
DONE  out  1  one-cycle pulse in the cycle after HI/LO take a new result
HI  out  W  HI register
LO  out  W  LO register

Behaviour:
- Reset: synchronous, active-high. On a RESET edge, HI=0, LO=0, BUSY=0, DONE=0 and the FSM goes to IDLE. RESET wins over START and aborts any divide; partial results are discarded.
- FSM states: IDLE, DIV, FIX.
- IDLE + START with a mult-class op: {HI,LO} updates at the next edge. DONE=1 for one cycle after that edge. The state stays IDLE and latency is 1.
  - MULT / MULTU: {HI,LO} = A*B, signed or unsigned, full 2W-bit result.
  - MADD / MADDU: {HI,LO} = {HI,LO} + A*B, modulo 2^(2W).
  - MSUB / MSUBU: {HI,LO} = {HI,LO} - A*B, modulo 2^(2W).
  - MTHI: HI=A, LO unchanged. MTLO: LO=A, HI unchanged.
- IDLE + START with DIV/DIVU: operand magnitudes and the result signs are latched, then the FSM goes to DIV with BUSY=1 from the next cycle.
  - DIV runs DIV_STEPS restoring iterations (a counter from DIV_STEPS-1 down to 0), then goes to FIX.
  - FIX applies the signs and writes HI=remainder, LO=quotient. BUSY drops, DONE pulses, and the FSM returns to IDLE.
  - Total: START at cycle 0 gives BUSY high for cycles 1..W+1 and HI/LO valid with DONE=1 at cycle W+2.
- Signed divide rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Overflow case (-2^(W-1) / -1): LO=0x8000_0000, HI=0, with no exception.
- Divide by zero (both signednesses):
  - LO=all ones for DIVU.
  - For DIV, LO=all ones if A>=0, else 1.
  - HI=A in both cases.
  - Latency is the same full W+2 cycles; there is no early exit.
- START while BUSY is ignored entirely: operands are not latched and HI/LO are not disturbed. The issuer must hold the op until BUSY=0.
- Undefined OP codes behave as a NOP: no write and no DONE.
- HI/LO hold their values between operations; during DIV they hold the pre-divide values.
- Reading HI/LO is combinational from the registers; there is no forwarding of in-flight results.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum logic [3:0] mdop_t: MULT=0, MULTU=1, MADD=2, MADDU=3, MSUB=4, MSUBU=5, DIV=6, DIVU=7, MTHI=8, MTLO=9.
  - typedef enum md_state_t {IDLE, DIV, FIX}.
  - helper function is_div(mdop_t).
- Sub-module div_iter (W parameter) owns the unsigned magnitude shift/subtract datapath and the step counter. It takes load and step inputs and exposes quotient, remainder and last.
- muldiv_seq keeps the FSM, sign handling, the multiplier/accumulator and the HI/LO registers.
- HI/LO use the team's ffd register cell with synchronous reset and enable.

Test Plan:
1. MULTU A=0xFFFF_FFFF, B=0xFFFF_FFFF -> next cycle HI=0xFFFF_FFFE, LO=0x0000_0001, DONE=1 for one cycle. Then MULT on the same operands -> HI=0, LO=1.
2. MTHI 0, MTLO 10, then MADD A=-3, B=4 -> {HI,LO}=0xFFFF_FFFF_FFFF_FFFE. Then MSUBU A=1, B=2 -> LO=0xFFFF_FFFC.
3. DIV A=-7, B=2 -> BUSY high exactly 33 cycles, then LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU A=7, B=2 -> LO=3, HI=1.
4. DIV A=0x8000_0000, B=-1 -> LO=0x8000_0000, HI=0. DIVU A=5, B=0 -> LO=0xFFFF_FFFF, HI=5 after the full latency.
5. DIV started, START MULT asserted at cycle 10 of the divide -> the MULT is ignored and the final HI/LO equal the divide result. RESET at cycle 15 -> next cycle BUSY=0, HI=LO=0, no DONE.
6. Randomised back-to-back ops against a reference model, W=32 and W=16 builds -> HI/LO match after every DONE, and START is never accepted while BUSY=1.
